alu_issue_unit: RTL
===================

# alu_issue_unit

Sequential initiator that drives the 8-bit ALU. It accepts one operation request at a time through a valid/ready handshake and reads source operands from a 4×8-bit register file. It then presents `operand1`/`operand2`/`ALU_sel` to the ALU, waits a programmable settle time, writes the result back and latches the 7-bit flag word. It sits between instruction decode and the ALU in the microprocessor datapath.

## Interface
- `SETTLE_CYCLES`, 2, number of clock edges the ALU inputs are held stable before capture; legal range 1–15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; combinational: state IDLE and `!ld_en` and `!rst`.
- `req_op`  in  8  ALU operation code, forwarded unchanged to `alu_sel`.
- `req_dst`  in  2  destination register index.
- `req_src1`  in  2  operand1 register index.
- `req_src2`  in  2  operand2 register index; unused when `req_use_imm`=1.
- `req_use_imm`  in  1  operand2 taken from `req_imm` instead of a register.
- `req_imm`  in  8  immediate operand.
- `ld_en`  in  1  direct register load strobe.
- `ld_addr`  in  2  load register index.
- `ld_data`  in  8  load value.
- `alu_op1`  out  8  to ALU `operand1`, registered.
- `alu_op2`  out  8  to ALU `operand2`, registered.
- `alu_sel`  out  8  to ALU `ALU_sel`, registered.
- `alu_result`  in  8  from ALU `operation_result`.
- `alu_flags`  in  7  from ALU `Flags` ([0]Z [1]C [2]S [3]P [4]I [5]D [6]V).
- `done`  out  1  one-cycle pulse: writeback performed.
- `flags_reg`  out  7  status register, flags of last completed op.
- `dbg_addr`  in  2  debug read index.
- `dbg_data`  out  8  combinational read of register `dbg_addr`.

## Operation
- State machine: IDLE, EXEC.
- IDLE:
  - `ld_en`=1 writes `ld_data` to `regs[ld_addr]` at the edge. `req_ready` is 0 that cycle, so a load always wins over a simultaneous request.
  - On `req_valid && req_ready`, at the edge the unit latches `req_dst`. It loads `alu_op1`←`regs[req_src1]` and `alu_op2`←(`req_use_imm` ? `req_imm` : `regs[req_src2]`), using pre-edge register values. It loads `alu_sel`←`req_op`, clears `cnt`, and moves to EXEC.
- EXEC:
  - `cnt` increments every edge.
  - At the edge where `cnt`==`SETTLE_CYCLES`−1, the unit:
    - writes `regs[dst]`←`alu_result`;
    - sets `flags_reg`←`alu_flags`;
    - sets `done`←1;
    - clears `alu_sel`←8'h00 (ALU default, result 0);
    - returns to IDLE.
  - `alu_op1`/`alu_op2` keep their values until the next accept.
  - `ld_en` in EXEC is ignored (no write).
- Opcodes are not checked; unknown codes are forwarded and whatever the ALU returns is written back.
- Division by zero is not special-cased: `alu_flags[6]` is captured as delivered.
- `src`==`dst` is legal: operands are read at accept, and the write happens at completion.
- Reset (any time, including mid-EXEC):
  - `regs`, `flags_reg`, `alu_op1`, `alu_op2`, `alu_sel` go to 0; `done`=0; state IDLE; `cnt`=0.
  - An in-flight op is discarded: no writeback, no `done`.

## Timing
- Accept at edge E0; ALU inputs are valid from E0 to the completion edge.
- Capture at edge E(`SETTLE_CYCLES`). `done` is high for exactly the following cycle.
- `req_ready` is high again in that same cycle, so a back-to-back accept can happen at edge E(`SETTLE_CYCLES`+1).
- Throughput is one op per `SETTLE_CYCLES`+1 cycles (3 with default).
- A request issued in the `done` cycle sees the just-written register value, so there are no read-after-write hazards.
- `flags_reg` and the written register change only on completion edges and on reset.
- `dbg_data` reflects a write from the edge after which it occurs.

## Test plan
All scenarios use the default `SETTLE_CYCLES`=2 and a stub ALU (combinational add/sub/div implementing the flag map above).

- **Add:** load R0=0x05, R1=0x03; issue `req_op`=0x01 src1=R0 src2=R1 dst=R2.
  - `alu_sel`=0x01 for 2 cycles.
  - `done` is high 2 edges after accept.
  - R2=0x08, `flags_reg[0]`=0, `flags_reg[1]`=0.
- **Wrap-around:** R0=0xFF, `req_use_imm`=1, `req_imm`=0x01, op 0x01, dst R3.
  - R3=0x00, `flags_reg[0]`=1, `flags_reg[1]`=1.
- **Divide by zero:** op 0x04, src1=R0 (0x10), imm 0x00.
  - `flags_reg[6]`=1; dst holds the stub's value; `done` pulses normally.
- **Back-to-back:** `req_valid` held high with op A (R1←R0+R0, R0=0x04) then op B (R2←R1+R1).
  - Accepts occur 3 cycles apart.
  - R1=0x08, R2=0x10; `done` pulses twice.
- **Load vs request:** `ld_en` (R0←0x7F) and `req_valid` asserted in the same IDLE cycle.
  - `req_ready`=0 and the load is performed.
  - The request is accepted next cycle and uses R0=0x7F.
- **Reset mid-op:** assert `rst` one cycle after accept.
  - All outputs read 0 immediately and `done` never pulses.
  - After release, `req_ready`=1 and `dbg_data` for the destination reads 0x00.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Sequential issue unit for the 8-bit ALU: reads operands from a 4x8 register
// file, holds them on the ALU for SETTLE_CYCLES edges, then writes back result and flags.
module alu_issue_unit #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_op_i,
  input  logic [1:0] req_dst_i,
  input  logic [1:0] req_src1_i,
  input  logic [1:0] req_src2_i,
  input  logic       req_use_imm_i,
  input  logic [7:0] req_imm_i,
  input  logic       ld_en_i,
  input  logic [1:0] ld_addr_i,
  input  logic [7:0] ld_data_i,
  output logic [7:0] alu_op1_o,
  output logic [7:0] alu_op2_o,
  output logic [7:0] alu_sel_o,
  input  logic [7:0] alu_result_i,
  input  logic [6:0] alu_flags_i,
  output logic       done_o,
  output logic [6:0] flags_reg_o,
  input  logic [1:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [1:0] dst_q;
  logic [7:0] regs_q [4];
  logic [7:0] op1_q;
  logic [7:0] op2_q;
  logic [7:0] sel_q;
  logic       done_q;
  logic [6:0] flags_q;
  logic       accept;

  // A pending load blocks acceptance so the load always wins the cycle.
  assign req_ready_o = (state_q == IDLE) && !ld_en_i && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ld_en_i) begin
            regs_q[ld_addr_i] <= ld_data_i;
          end else if (accept) begin
            dst_q   <= req_dst_i;
            op1_q   <= regs_q[req_src1_i];
            op2_q   <= req_use_imm_i ? req_imm_i : regs_q[req_src2_i];
            sel_q   <= req_op_i;
            cnt_q   <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + 4'd1;
          // Operands stay on the ALU after completion; only the opcode returns to the default.
          if (cnt_q == CNT_LAST) begin
            regs_q[dst_q] <= alu_result_i;
            flags_q       <= alu_flags_i;
            done_q        <= 1'b1;
            sel_q         <= 8'h00;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op1_o   = op1_q;
  assign alu_op2_o   = op2_q;
  assign alu_sel_o   = sel_q;
  assign done_o      = done_q;
  assign flags_reg_o = flags_q;
  assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule
